// File: rtl/axi_read_dma.sv
// rtl/axi_read_dma.sv - single-outstanding AXI4 read DMA into an output stream; optional byte flip via AXI_RD_FLIP_BYTE_EN
module axi_read_dma #(
    parameter int                       RD_ADDR_WIDTH      = 32,
    parameter int                       RD_DATA_WIDTH      = 64,
    parameter int                       RD_LIN             = 16,
    parameter logic [RD_ADDR_WIDTH-1:0] RD_BASE_ADDR       = '0,
    parameter int                       RD_REGION_BYTES    = 65536,
    parameter int                       RD_TLAST_PER_BURST = 0
) (
    input  logic                     M_RD_aclk,
    input  logic                     M_RD_areset,
    input  logic                     i_start,
    input  logic [15:0]              i_nburst,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [1:0]               o_err,
    output logic [RD_DATA_WIDTH-1:0] M_RD_tdata,
    output logic                     M_RD_tvalid,
    output logic                     M_RD_tlast,
    input  logic                     M_RD_tready,
    output logic [3:0]               m_axi_arid,
    output logic [RD_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]               m_axi_arlen,
    output logic [2:0]               m_axi_arsize,
    output logic [1:0]               m_axi_arburst,
    output logic                     m_axi_arlock,
    output logic [3:0]               m_axi_arcache,
    output logic [2:0]               m_axi_arprot,
    output logic [3:0]               m_axi_arqos,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [RD_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam int                       NBYTES      = RD_DATA_WIDTH / 8;
    localparam int                       BURST_BYTES = RD_LIN * NBYTES;
    localparam logic [2:0]               C_ARSIZE    = 3'($clog2(NBYTES));
    localparam logic [7:0]               C_ARLEN     = 8'(RD_LIN - 1);
    localparam logic [8:0]               C_LAST_BEAT = 9'(RD_LIN - 1);
    localparam logic [RD_ADDR_WIDTH-1:0] C_BURST_INC = RD_ADDR_WIDTH'(BURST_BYTES);
    localparam logic [RD_ADDR_WIDTH-1:0] C_RING_END  = RD_BASE_ADDR + RD_ADDR_WIDTH'(RD_REGION_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_arvalid;
    logic [RD_ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]               r_arlen;
    logic [2:0]               r_arsize;
    logic [1:0]               r_arburst;
    logic [RD_ADDR_WIDTH-1:0] r_ptr;
    logic [8:0]               r_beat;
    logic [15:0]              r_left;
    logic                     r_busy;
    logic                     r_done;
    logic [1:0]               r_err;

    logic                     w_in_data;
    logic                     w_r_hs;
    logic                     w_last_beat;
    logic                     w_tlast_sel;
    logic [RD_ADDR_WIDTH-1:0] w_ptr_sum;
    logic [RD_ADDR_WIDTH-1:0] w_ptr_next;
    logic [RD_DATA_WIDTH-1:0] w_rdata_fmt;

    assign w_in_data   = (r_state == S_DATA);
    assign w_r_hs      = w_in_data && m_axi_rvalid && M_RD_tready;
    assign w_last_beat = (r_beat == C_LAST_BEAT);
    // Frame-level tlast needs the final beat of the final burst; r_left still counts the current burst.
    assign w_tlast_sel = (RD_TLAST_PER_BURST != 0) ? w_last_beat : (w_last_beat && (r_left == 16'd1));
    assign w_ptr_sum   = r_ptr + C_BURST_INC;
    assign w_ptr_next  = (w_ptr_sum == C_RING_END) ? RD_BASE_ADDR : w_ptr_sum;

`ifdef AXI_RD_FLIP_BYTE_EN
    // Byte-reverse the read beat: byte 0 of the AXI beat lands in the MSB byte of the stream.
    always_comb begin
        w_rdata_fmt = '0;
        for (int b = 0; b < NBYTES; b++) begin
            w_rdata_fmt[b*8 +: 8] = m_axi_rdata[(NBYTES-1-b)*8 +: 8];
        end
    end
`else
    assign w_rdata_fmt = m_axi_rdata;
`endif

    assign M_RD_tvalid   = w_in_data && m_axi_rvalid;
    assign M_RD_tdata    = w_in_data ? w_rdata_fmt : '0;
    assign M_RD_tlast    = w_in_data && m_axi_rvalid && w_tlast_sel;
    assign m_axi_rready  = w_in_data && M_RD_tready;

    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = r_arsize;
    assign m_axi_arburst = r_arburst;
    assign m_axi_arid    = 4'd0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;

    // Frame sequencer: issue one burst, drain its beats, repeat until the frame count is exhausted.
    always_ff @(posedge M_RD_aclk) begin
        if (M_RD_areset) begin
            r_state   <= S_IDLE;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_ptr     <= RD_BASE_ADDR;
            r_beat    <= '0;
            r_left    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_err  <= '0;
                        r_busy <= 1'b1;
                        r_beat <= '0;
                        if (i_nburst != 16'd0) begin
                            r_left    <= i_nburst;
                            r_arvalid <= 1'b1;
                            r_araddr  <= r_ptr;
                            r_arlen   <= C_ARLEN;
                            r_arsize  <= C_ARSIZE;
                            r_arburst <= 2'b01;
                            r_state   <= S_ADDR;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_ptr     <= w_ptr_next;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_r_hs) begin
                        if (m_axi_rresp != 2'b00) begin
                            r_err[0] <= 1'b1;
                        end
                        if (m_axi_rlast != w_last_beat) begin
                            r_err[1] <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_beat <= '0;
                            r_left <= r_left - 16'd1;
                            if (r_left != 16'd1) begin
                                r_arvalid <= 1'b1;
                                r_araddr  <= r_ptr;
                                r_state   <= S_ADDR;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_beat <= r_beat + 9'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_dma.sv
// tb/tb_axi_read_dma.sv - directed self-checking bench for axi_read_dma with a single-outstanding AXI read slave model
module tb_axi_read_dma;

    logic        M_RD_aclk;
    logic        M_RD_areset;
    logic        i_start;
    logic [15:0] i_nburst;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_err;
    logic [63:0] M_RD_tdata;
    logic        M_RD_tvalid;
    logic        M_RD_tlast;
    logic        M_RD_tready;
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    axi_read_dma #(
        .RD_ADDR_WIDTH     (32),
        .RD_DATA_WIDTH     (64),
        .RD_LIN            (16),
        .RD_BASE_ADDR      (32'h0),
        .RD_REGION_BYTES   (2048),
        .RD_TLAST_PER_BURST(0)
    ) dut (
        .M_RD_aclk    (M_RD_aclk),
        .M_RD_areset  (M_RD_areset),
        .i_start      (i_start),
        .i_nburst     (i_nburst),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .M_RD_tdata   (M_RD_tdata),
        .M_RD_tvalid  (M_RD_tvalid),
        .M_RD_tlast   (M_RD_tlast),
        .M_RD_tready  (M_RD_tready),
        .m_axi_arid   (m_axi_arid),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock (m_axi_arlock),
        .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arqos  (m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    initial M_RD_aclk = 1'b0;
    always #5 M_RD_aclk = ~M_RD_aclk;

    int n_chk = 0;
    int n_err = 0;

    // slave model state
    logic        s_active = 1'b0;
    logic        s_pend = 1'b0;
    logic [31:0] s_addr = '0;
    int          s_beat = 0;
    logic        inj_rresp = 1'b0;
    logic        inj_rlast = 1'b0;
    int          ar_stall = 0;
    logic        stall_seen = 1'b0;
    logic [31:0] stall_addr = '0;
    int          stab_bad = 0;
    logic        tready_toggle = 1'b0;

    // observation
    logic [31:0] ar_q[$];
    logic [63:0] b_data[$];
    logic        b_last[$];
    int          done_cnt = 0;
    int          arvalid_seen = 0;
    int          mirror_bad = 0;
    int          tlast_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat(input logic [31:0] a, input int b);
        logic [63:0] d;
        logic [63:0] f;
        d = {a, 32'(b)};
        f = d;
`ifdef AXI_RD_FLIP_BYTE_EN
        for (int k = 0; k < 8; k++) f[k*8 +: 8] = d[(7-k)*8 +: 8];
`endif
        return f;
    endfunction

    // One clock: drive slave outputs, observe handshakes due at the coming edge, advance past it.
    task automatic cycle();
        if (s_active) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {s_addr, 32'(s_beat)};
            m_axi_rlast  = inj_rlast ? (s_beat == 14) : (s_beat == 15);
            m_axi_rresp  = (inj_rresp && s_beat == 4) ? 2'd2 : 2'd0;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'd0;
        end
        m_axi_arready = (ar_stall == 0);
        if (tready_toggle) M_RD_tready = ~M_RD_tready;
        #1;
        if (m_axi_arvalid) arvalid_seen++;
        if (m_axi_rready && !M_RD_tready) mirror_bad++;
        if (M_RD_tlast && !M_RD_tvalid) tlast_bad++;
        if (o_done) done_cnt++;
        if (M_RD_areset) begin
            s_active  = 1'b0;
            s_pend    = 1'b0;
            inj_rresp = 1'b0;
            inj_rlast = 1'b0;
        end else begin
            if (m_axi_arvalid && !m_axi_arready) begin
                if (!stall_seen) begin
                    stall_seen = 1'b1;
                    stall_addr = m_axi_araddr;
                end else if (m_axi_araddr !== stall_addr) begin
                    stab_bad++;
                end
                ar_stall--;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (stall_seen && m_axi_araddr !== stall_addr) stab_bad++;
                stall_seen = 1'b0;
                ar_q.push_back(m_axi_araddr);
                s_pend = 1'b1;
                s_addr = m_axi_araddr;
            end
            if (M_RD_tvalid && M_RD_tready) begin
                b_data.push_back(M_RD_tdata);
                b_last.push_back(M_RD_tlast);
            end
            if (m_axi_rvalid && m_axi_rready) begin
                s_beat++;
                if (s_beat == 16) begin
                    s_active  = 1'b0;
                    inj_rresp = 1'b0;
                    inj_rlast = 1'b0;
                end
            end
            if (s_pend) begin
                s_pend   = 1'b0;
                s_active = 1'b1;
                s_beat   = 0;
            end
        end
        @(posedge M_RD_aclk);
        @(negedge M_RD_aclk);
    endtask

    task automatic start_frame(input logic [15:0] n);
        ar_q.delete();
        b_data.delete();
        b_last.delete();
        i_start  = 1'b1;
        i_nburst = n;
        cycle();
        i_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        done_cnt = 0;
        while (done_cnt == 0 && i < budget) begin
            cycle();
            i++;
        end
        check({tag, "_done"}, 64'(done_cnt), 64'd1);
        cycle();
        cycle();
        check({tag, "_done_pulse"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int nb, input logic [31:0] a0);
        int bad_a, bad_d, bad_l;
        logic [31:0] a;
        bad_a = 0;
        bad_d = 0;
        bad_l = 0;
        check({tag, "_ar_count"}, 64'(ar_q.size()), 64'(nb));
        check({tag, "_beat_count"}, 64'(b_data.size()), 64'(nb * 16));
        foreach (ar_q[i]) begin
            a = 32'((int'(a0) + i * 128) % 2048);
            if (ar_q[i] !== a) bad_a++;
        end
        foreach (b_data[j]) begin
            a = 32'((int'(a0) + (j / 16) * 128) % 2048);
            if (b_data[j] !== exp_beat(a, j % 16)) bad_d++;
            if (b_last[j] !== (j == nb * 16 - 1)) bad_l++;
        end
        check({tag, "_ar_addr_bad"}, 64'(bad_a), 64'd0);
        check({tag, "_data_bad"}, 64'(bad_d), 64'd0);
        check({tag, "_tlast_bad"}, 64'(bad_l), 64'd0);
    endtask

    initial begin
        M_RD_areset   = 1'b1;
        i_start       = 1'b0;
        i_nburst      = '0;
        M_RD_tready   = 1'b1;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        m_axi_rlast   = 1'b0;
        @(negedge M_RD_aclk);
        cycle();
        cycle();
        M_RD_areset = 1'b0;

        // reset state
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_tvalid", 64'(M_RD_tvalid), 64'd0);
        check("rst_rready", 64'(m_axi_rready), 64'd0);
        check("rst_araddr", 64'(m_axi_araddr), 64'd0);
        check("tie_arcache", 64'(m_axi_arcache), 64'd3);

        // single burst frame from ring base
        start_frame(16'd1);
        check("a_arvalid", 64'(m_axi_arvalid), 64'd1);
        check("a_araddr", 64'(m_axi_araddr), 64'h0);
        check("a_arlen", 64'(m_axi_arlen), 64'd15);
        check("a_arsize", 64'(m_axi_arsize), 64'd3);
        check("a_arburst", 64'(m_axi_arburst), 64'd1);
        check("a_busy", 64'(o_busy), 64'd1);
        wait_done("a", 200);
        check_frame("a", 1, 32'h0);
        check("a_busy_end", 64'(o_busy), 64'd0);

        // response error on beat 5 and early rlast on beat 15
        inj_rresp = 1'b1;
        inj_rlast = 1'b1;
        start_frame(16'd1);
        wait_done("e", 200);
        check_frame("e", 1, 32'h80);
        check("e_err", 64'(o_err), 64'd3);
        cycle();
        cycle();
        cycle();
        check("e_err_sticky", 64'(o_err), 64'd3);

        // reset while beat 7 is on the bus
        inj_rresp = 1'b1;
        start_frame(16'd1);
        check("r_err_clear_on_start", 64'(o_err), 64'd0);
        for (int k = 0; k < 200 && b_data.size() < 6; k++) cycle();
        check("r_err_mid", 64'(o_err), 64'd1);
        M_RD_areset = 1'b1;
        cycle();
        M_RD_areset = 1'b0;
        check("r_beats_before_abort", 64'(b_data.size()), 64'd6);
        check("r_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("r_rready", 64'(m_axi_rready), 64'd0);
        check("r_tvalid", 64'(M_RD_tvalid), 64'd0);
        check("r_tlast", 64'(M_RD_tlast), 64'd0);
        check("r_tdata", M_RD_tdata, 64'd0);
        check("r_busy", 64'(o_busy), 64'd0);
        check("r_done", 64'(o_done), 64'd0);
        check("r_err", 64'(o_err), 64'd0);
        check("r_arlen", 64'(m_axi_arlen), 64'd0);
        check("r_arsize", 64'(m_axi_arsize), 64'd0);
        check("r_arburst", 64'(m_axi_arburst), 64'd0);
        check("r_araddr", 64'(m_axi_araddr), 64'd0);

        // 20 bursts across the 2 KiB ring, first AR held off for 3 cycles
        ar_stall = 3;
        start_frame(16'd20);
        check("w_araddr_base", 64'(m_axi_araddr), 64'h0);
        wait_done("w", 1000);
        check_frame("w", 20, 32'h0);
        check("w_wrap_addr", 64'(ar_q.size() > 16 ? ar_q[16] : 32'hFFFF_FFFF), 64'h0);
        check("w_ar_stable", 64'(stab_bad), 64'd0);

        // tready toggling, extra start mid-frame ignored; frame continues at 0x200
        tready_toggle = 1'b1;
        mirror_bad = 0;
        tlast_bad = 0;
        start_frame(16'd2);
        check("t_araddr", 64'(m_axi_araddr), 64'h200);
        repeat (5) cycle();
        i_start  = 1'b1;
        i_nburst = 16'd5;
        cycle();
        i_start  = 1'b0;
        wait_done("t", 400);
        tready_toggle = 1'b0;
        M_RD_tready = 1'b1;
        check_frame("t", 2, 32'h200);
        check("t_rready_mirror", 64'(mirror_bad), 64'd0);
        check("t_tlast_gated", 64'(tlast_bad), 64'd0);

        // zero-burst frame: done two edges after start, no AR traffic
        arvalid_seen = 0;
        done_cnt = 0;
        start_frame(16'd0);
        check("z_done_early", 64'(o_done), 64'd0);
        check("z_busy", 64'(o_busy), 64'd1);
        i_start  = 1'b1;
        i_nburst = 16'd3;
        cycle();
        i_start  = 1'b0;
        check("z_done", 64'(o_done), 64'd1);
        check("z_busy_end", 64'(o_busy), 64'd0);
        cycle();
        check("z_done_off", 64'(o_done), 64'd0);
        repeat (5) cycle();
        check("z_no_arvalid", 64'(arvalid_seen), 64'd0);
        check("z_no_frame", 64'(o_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi_read_dma.md
AXI_READ_DMA -- requirements
Module: axi_read_dma

Interface
REQ-001 SHALL have parameter RD_ADDR_WIDTH, 32, AXI address width.
REQ-002 SHALL have parameter RD_DATA_WIDTH, 64, data width; legal 32/64/128/256.
REQ-003 SHALL have parameter RD_LIN, 16, beats per burst; legal 1-256.
REQ-004 SHALL have parameter RD_BASE_ADDR, 0, ring start address; 4096-aligned.
REQ-005 SHALL have parameter RD_REGION_BYTES, 65536, ring size; multiple of burst bytes (RD_LIN*RD_DATA_WIDTH/8, which SHALL divide 4096).
REQ-006 SHALL have parameter RD_TLAST_PER_BURST, 0, 0 = tlast on final frame beat, 1 = tlast on every burst's final beat.
REQ-007 SHALL have port M_RD_aclk  in  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port M_RD_areset  in  1  synchronous active-high reset.
REQ-009 SHALL have port i_start  in  1  frame start pulse.
REQ-010 SHALL have port i_nburst  in  16  bursts per frame, sampled with i_start.
REQ-011 SHALL have port o_busy  out  1  high from accepted start until done.
REQ-012 SHALL have port o_done  out  1  one-cycle pulse at frame end.
REQ-013 SHALL have port o_err  out  2  sticky; [0] rresp!=0, [1] rlast mismatch.
REQ-014 SHALL have ports M_RD_tdata out RD_DATA_WIDTH, M_RD_tvalid out 1, M_RD_tlast out 1, M_RD_tready in 1: output stream.
REQ-015 SHALL have AXI AR ports m_axi_araddr out RD_ADDR_WIDTH, m_axi_arlen out 8, m_axi_arsize out 3, m_axi_arburst out 2, m_axi_arvalid out 1, m_axi_arready in 1.
REQ-016 SHALL have AXI R ports m_axi_rdata in RD_DATA_WIDTH, m_axi_rresp in 2, m_axi_rlast in 1, m_axi_rvalid in 1, m_axi_rready out 1.
REQ-017 SHALL tie m_axi_arid=0, arlock=0, arcache=4'b0011, arprot=0, arqos=0.

Function
REQ-018 SHALL implement FSM IDLE, ADDR, DATA, DONE; one burst outstanding at most.
REQ-019 IDLE: i_start with i_nburst>0 -> ADDR next cycle, arvalid high that cycle; i_nburst==0 -> DONE, no AXI traffic.
REQ-020 i_start outside IDLE SHALL be ignored.
REQ-021 ADDR: arvalid, araddr, arlen=RD_LIN-1, arsize=log2(RD_DATA_WIDTH/8), arburst=INCR held stable until arvalid&&arready; then DATA.
REQ-022 DATA: M_RD_tvalid=m_axi_rvalid, m_axi_rready=M_RD_tready, M_RD_tdata=m_axi_rdata combinationally; all three 0 outside DATA.
REQ-023 Beat counter SHALL increment on rvalid&&rready and clear at burst end (counter==RD_LIN-1 handshake).
REQ-024 Burst end SHALL go to ADDR (no idle cycle) if bursts remain, else DONE.
REQ-025 Address pointer SHALL advance by burst bytes per issued burst; if next value reaches RD_BASE_ADDR+RD_REGION_BYTES it SHALL wrap to RD_BASE_ADDR; pointer persists across frames.
REQ-026 M_RD_tlast SHALL assert with the beat selected by RD_TLAST_PER_BURST, only while tvalid high.
REQ-027 o_err[0] SHALL set on any handshaked beat with rresp!=0; o_err[1] SHALL set when rlast differs from counter==RD_LIN-1; both clear on accepted start; transfer continues regardless.
REQ-028 DONE: o_done high one cycle, then IDLE; o_busy low in IDLE only.

Reset
REQ-029 On M_RD_areset (sync, active-high), next edge: state IDLE, arvalid 0, rready 0, tvalid 0, tlast 0, o_done 0, o_busy 0, o_err 0, counters 0, pointer RD_BASE_ADDR, araddr/arlen/arsize/arburst 0.
REQ-030 Reset mid-burst SHALL abort immediately; no completion of outstanding beats is attempted.

Configuration
REQ-031 With macro AXI_RD_FLIP_BYTE_EN defined, M_RD_tdata SHALL be m_axi_rdata byte-reversed (byte 0 to MSB byte); undefined, pass-through unchanged; timing identical.

Verification
REQ-032 Reset, RD_LIN=16, 64-bit, i_nburst=1, tready=1 -> one AR at 0x0 arlen=15 arsize=3, 16 beats, tlast on beat 16, o_done 1 cycle.
REQ-033 i_nburst=20, RD_REGION_BYTES=2048 (16 bursts) -> araddr 0x0..0x780 then 0x0..0x180; next frame starts 0x200.
REQ-034 tready toggling 1/0 every cycle, i_nburst=2 -> rready mirrors tready, all 32 beats delivered in order, no drops.
REQ-035 rresp=2 on beat 5 and rlast early on beat 15 -> o_err=2'b11 sticky until next start; frame still completes.
REQ-036 i_nburst=0 -> o_done pulse 2 cycles after start, arvalid never asserted; start during busy ignored.
REQ-037 Reset asserted during beat 7 -> next cycle all outputs at reset values; new start issues AR at RD_BASE_ADDR.
